alu_exec: RTL and testbench

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/seq_muldiv.sv | 98 +++++++++
 rtl/alu_exec.sv | 128 ++++++++++++
 tb/tb_alu_exec.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: datapath width, operation codes
// (also consumed by the ALU control decoder) and the execute FSM state type.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_MUL = 4'b0011;
    localparam logic [3:0] ALU_DIV = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SLL = 4'b1110;
    localparam logic [3:0] ALU_SRL = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Single-cycle result; codes without a single-cycle meaning yield zero.
    function automatic logic [ALU_WIDTH-1:0] alu_single(
        input logic [3:0]           op,
        input logic [ALU_WIDTH-1:0] a,
        input logic [ALU_WIDTH-1:0] b
    );
        logic [ALU_WIDTH-1:0] r;
        r = '0;
        case (op)
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_SLT: r = ($signed(a) < $signed(b)) ? {{(ALU_WIDTH-1){1'b0}}, 1'b1} : '0;
            ALU_NOR: r = ~(a | b);
            ALU_SLL: r = a << b[4:0];
            ALU_SRL: r = a >> b[4:0];
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative signed multiply (shift-add) and divide (restoring) on magnitudes,
// one bit per cycle for 32 cycles, with sign fix-up applied to the final step.
module seq_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);

    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [WIDTH-1:0]   b_mag_r;
    logic [4:0]         cnt_r;
    logic               busy_r;
    logic               op_div_r;
    logic               neg_lo_r;
    logic               neg_hi_r;

    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     trial_s;
    logic [WIDTH-1:0]   hi_n_s;
    logic [WIDTH-1:0]   lo_n_s;
    logic [2*WIDTH-1:0] prod_s;

    // One iteration step; hi/lo hold partial product or remainder/quotient.
    always_comb begin
        sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_mag_r} : {(WIDTH+1){1'b0}});
        trial_s = {hi_r, lo_r[WIDTH-1]} - {1'b0, b_mag_r};
        hi_n_s  = '0;
        lo_n_s  = '0;
        if (op_div_r) begin
            if (!trial_s[WIDTH]) begin
                hi_n_s = trial_s[WIDTH-1:0];
                lo_n_s = {lo_r[WIDTH-2:0], 1'b1};
            end else begin
                hi_n_s = {hi_r[WIDTH-2:0], lo_r[WIDTH-1]};
                lo_n_s = {lo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_n_s = sum_s[WIDTH:1];
            lo_n_s = {sum_s[0], lo_r[WIDTH-1:1]};
        end
    end

    // Sign fix-up: quotient/product negated on sign mismatch, remainder follows dividend.
    always_comb begin
        prod_s = {hi_n_s, lo_n_s};
        res_lo = '0;
        res_hi = '0;
        if (op_div_r) begin
            res_lo = neg_lo_r ? -lo_n_s : lo_n_s;
            res_hi = neg_hi_r ? -hi_n_s : hi_n_s;
        end else begin
            {res_hi, res_lo} = neg_lo_r ? -prod_s : prod_s;
        end
        done = busy_r && (cnt_r == 5'd31);
    end

    // Operand capture on start, then 32 iteration steps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_r     <= '0;
            lo_r     <= '0;
            b_mag_r  <= '0;
            cnt_r    <= 5'd0;
            busy_r   <= 1'b0;
            op_div_r <= 1'b0;
            neg_lo_r <= 1'b0;
            neg_hi_r <= 1'b0;
        end else if (start) begin
            hi_r     <= '0;
            lo_r     <= a[WIDTH-1] ? -a : a;
            b_mag_r  <= b[WIDTH-1] ? -b : b;
            cnt_r    <= 5'd0;
            busy_r   <= 1'b1;
            op_div_r <= op_div;
            neg_lo_r <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_hi_r <= a[WIDTH-1];
        end else if (busy_r) begin
            hi_r   <= hi_n_s;
            lo_r   <= lo_n_s;
            cnt_r  <= cnt_r + 5'd1;
            busy_r <= (cnt_r != 5'd31);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle operations complete the cycle after acceptance,
// mul/div run through seq_muldiv; results are held until the next completion.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    state_t           state_r;
    logic [WIDTH-1:0] result_lo_r;
    logic [WIDTH-1:0] result_hi_r;
    logic             zero_r;
    logic             busy_r;
    logic             done_r;
    logic             div_by_zero_r;

    logic             accept_s;
    logic             is_div_s;
    logic             mdu_start_s;
    logic [WIDTH-1:0] single_lo_s;
    logic             mdu_done_s;
    logic [WIDTH-1:0] mdu_lo_s;
    logic [WIDTH-1:0] mdu_hi_s;

    // Acceptance and dispatch: divide by zero is finished here in one cycle.
    always_comb begin
        accept_s    = start && (state_r != ST_RUN);
        is_div_s    = (alu_control == ALU_DIV);
        mdu_start_s = accept_s && ((alu_control == ALU_MUL) ||
                                   (is_div_s && (src_b != '0)));
        single_lo_s = alu_single(alu_control, src_a, src_b);
    end

    seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mdu_start_s),
        .op_div (is_div_s),
        .a      (src_a),
        .b      (src_b),
        .done   (mdu_done_s),
        .res_lo (mdu_lo_s),
        .res_hi (mdu_hi_s)
    );

    // Execute FSM with result registers written only on completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            result_lo_r   <= '0;
            result_hi_r   <= '0;
            zero_r        <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            div_by_zero_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept_s && mdu_start_s) begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end else if (accept_s) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        if (is_div_s) begin
                            result_lo_r   <= '1;
                            result_hi_r   <= src_a;
                            zero_r        <= 1'b0;
                            div_by_zero_r <= 1'b1;
                        end else begin
                            result_lo_r   <= single_lo_s;
                            result_hi_r   <= '0;
                            zero_r        <= (single_lo_s == '0);
                            div_by_zero_r <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (mdu_done_s) begin
                        state_r       <= ST_DONE;
                        busy_r        <= 1'b0;
                        done_r        <= 1'b1;
                        result_lo_r   <= mdu_lo_s;
                        result_hi_r   <= mdu_hi_s;
                        zero_r        <= (mdu_lo_s == '0);
                        div_by_zero_r <= 1'b0;
                    end else begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign result_lo   = result_lo_r;
    assign result_hi   = result_hi_r;
    assign zero        = zero_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = div_by_zero_r;

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: directed corner cases plus randomized traffic,
// checked against an arithmetic reference model.
module tb_alu_exec;

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_MUL = 4'b0011;
    localparam logic [3:0] C_DIV = 4'b0100;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_SLT = 4'b0111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  alu_control;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic        zero;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    always #5 clk = ~clk;

    alu_exec #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .zero        (zero),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        z;
        logic        dbz;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t last;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_from = 1;
    int   busy_to = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        e.lo = 32'd0; e.hi = 32'd0; e.dbz = 1'b0; e.cyc = 0;
        case (op)
            4'b0000: e.lo = a & b;
            4'b0001: e.lo = a | b;
            4'b0010: e.lo = a + b;
            4'b0110: e.lo = a - b;
            4'b0111: e.lo = (sa < sb) ? 32'd1 : 32'd0;
            4'b1100: e.lo = ~(a | b);
            4'b1110: e.lo = a << b[4:0];
            4'b1111: e.lo = a >> b[4:0];
            4'b0011: begin
                p = sa * sb;
                e.lo = p[31:0];
                e.hi = p[63:32];
            end
            4'b0100: begin
                if (b == 32'd0) begin
                    e.lo = 32'hFFFF_FFFF; e.hi = a; e.dbz = 1'b1;
                end else begin
                    p = sa / sb;
                    e.lo = p[31:0];
                    p = sa % sb;
                    e.hi = p[31:0];
                end
            end
            default: e.lo = 32'd0;
        endcase
        e.z = (e.lo == 32'd0);
        return e;
    endfunction

    // Issue one operation at a negedge where the DUT can accept; return in its DONE cycle.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit mid_pulse);
        exp_t e;
        bit   it;
        alu_control = op; src_a = a; src_b = b; start = 1'b1;
        e  = model(op, a, b);
        it = (op == C_MUL) || (op == C_DIV && b != 32'd0);
        e.cyc = cyc + (it ? 33 : 1);
        sb_q.push_back(e);
        if (it) begin
            busy_from = cyc + 1;
            busy_to   = cyc + 32;
        end
        @(negedge clk);
        start = 1'b0;
        alu_control = 4'($urandom); src_a = $urandom; src_b = $urandom;
        if (it) begin
            for (int i = 0; i < 32; i++) begin
                if (mid_pulse && i == 8) begin
                    start = 1'b1;
                    alu_control = C_ADD;
                end
                @(negedge clk);
                start = 1'b0;
            end
        end
    endtask

    // Monitor: compares every cycle against the scoreboard and the last completed result.
    initial begin
        exp_t e;
        bit   exp_busy;
        bit   exp_done;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
            chk("busy", {63'd0, busy}, {63'd0, exp_busy});
            exp_done = (sb_q.size() > 0) && (sb_q[0].cyc == cyc);
            chk("done", {63'd0, done}, {63'd0, exp_done});
            if (exp_done) begin
                e = sb_q.pop_front();
                last = e;
            end
            chk("result_lo", {32'd0, result_lo}, {32'd0, last.lo});
            chk("result_hi", {32'd0, result_hi}, {32'd0, last.hi});
            chk("zero", {63'd0, zero}, {63'd0, last.z});
            chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, last.dbz});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] pick_operand();
        logic [31:0] specials [6];
        specials[0] = 32'h0000_0000; specials[1] = 32'hFFFF_FFFF;
        specials[2] = 32'h8000_0000; specials[3] = 32'h7FFF_FFFF;
        specials[4] = 32'h0000_0001; specials[5] = 32'h0000_0007;
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
        else return $urandom;
    endfunction

    initial begin
        last.lo = 32'd0; last.hi = 32'd0; last.z = 1'b0; last.dbz = 1'b0; last.cyc = 0;
        rst_n = 1'b0; start = 1'b0; alu_control = 4'd0; src_a = 32'd0; src_b = 32'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        send(C_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        send(C_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        send(C_SUB, 32'd5, 32'd5, 1'b0);
        send(C_MUL, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
        send(C_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        send(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        send(C_DIV, 32'd9, 32'd0, 1'b0);
        send(C_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0);
        @(negedge clk);

        // Reset at cycle T+10 of a multiply; a start during reset must be ignored.
        alu_control = C_MUL; src_a = 32'h1234_5678; src_b = 32'h0000_0777; start = 1'b1;
        begin
            exp_t e;
            e = model(C_MUL, 32'h1234_5678, 32'h0000_0777);
            e.cyc = cyc + 33;
            sb_q.push_back(e);
            busy_from = cyc + 1;
            busy_to   = cyc + 32;
        end
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1; alu_control = C_ADD; src_a = 32'd1; src_b = 32'd2;
        sb_q.delete();
        last.lo = 32'd0; last.hi = 32'd0; last.z = 1'b0; last.dbz = 1'b0;
        busy_from = 1; busy_to = 0;
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);
        send(C_ADD, 32'd40, 32'd2, 1'b0);

        for (int n = 0; n < 80; n++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) op = ($urandom_range(0, 1) == 0) ? C_MUL : C_DIV;
            send(op, pick_operand(), pick_operand(), bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
